// File: rtl/millis_stopwatch.sv
// millis_stopwatch: free-running millisecond elapsed-time counter.
// The CPU starts, stops and clears it through a byte-wide register port and
// reads the 16-bit count tear-free: reading the low byte latches the high
// byte into a shadow register, which is read back afterwards.
// Optional event capture is enabled by defining MILLIS_STOPWATCH_CAPTURE_EN.
module millis_stopwatch #(
  parameter logic [15:0] SHORT_COUNT_START = 16'd49999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  input  logic       write_en,
  input  logic       read_en,
  output logic [7:0] data_out,
  output logic       running,
  output logic       overflow,
  input  logic       capture_in
);

  logic [15:0] prescaler_q, prescaler_d;
  logic [15:0] msCount_q, msCount_d;
  logic [7:0]  shadowHi_q, shadowHi_d;
  logic [7:0]  dataOut_q, dataOut_d;
  logic        running_q, running_d;
  logic        overflow_q, overflow_d;

  logic ctrlWrite;
  logic startCmd;
  logic stopCmd;
  logic clearCmd;
  logic msTick;
  logic capturePending;
  logic unusedCtrlBits;

  assign ctrlWrite = write_en && (addr == 2'd0);
  assign startCmd  = ctrlWrite && data_in[0];
  assign stopCmd   = ctrlWrite && data_in[1];
  assign clearCmd  = ctrlWrite && data_in[2];
  assign msTick    = running_q && (prescaler_q == 16'd0);

  assign unusedCtrlBits = ^data_in[7:3];

`ifdef MILLIS_STOPWATCH_CAPTURE_EN
  logic        captureSync1_q;
  logic        captureSync2_q;
  logic        captureDelay_q;
  logic        captureEdge;
  logic [15:0] captureReg_q, captureReg_d;
  logic        capturePending_q, capturePending_d;

  assign captureEdge    = captureSync2_q && !captureDelay_q;
  assign capturePending = capturePending_q;

  // Synchronise the asynchronous event pin and keep one extra stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      captureSync1_q <= 1'b0;
      captureSync2_q <= 1'b0;
      captureDelay_q <= 1'b0;
    end else begin
      captureSync1_q <= capture_in;
      captureSync2_q <= captureSync1_q;
      captureDelay_q <= captureSync2_q;
    end
  end

  // Snapshot the pre-tick count on a rising edge; an addr3 read clears pending unless a new edge lands
  always_comb begin
    captureReg_d     = captureReg_q;
    capturePending_d = capturePending_q;
    if (read_en && (addr == 2'd3)) begin
      capturePending_d = 1'b0;
    end
    if (captureEdge) begin
      captureReg_d     = msCount_q;
      capturePending_d = 1'b1;
    end
  end

  // Capture register and pending flag
  always_ff @(posedge clk) begin
    if (reset) begin
      captureReg_q     <= 16'd0;
      capturePending_q <= 1'b0;
    end else begin
      captureReg_q     <= captureReg_d;
      capturePending_q <= capturePending_d;
    end
  end
`else
  logic unusedCaptureIn;

  assign unusedCaptureIn = capture_in;
  assign capturePending  = 1'b0;
`endif

  // Counting and control: STOP freezes everything including a coincident tick, CLEAR beats the increment
  always_comb begin
    prescaler_d = prescaler_q;
    msCount_d   = msCount_q;
    overflow_d  = overflow_q;
    running_d   = running_q;

    if (running_q) begin
      prescaler_d = msTick ? SHORT_COUNT_START : (prescaler_q - 16'd1);
    end
    if (msTick) begin
      msCount_d = msCount_q + 16'd1;
      if (msCount_q == 16'hFFFF) begin
        overflow_d = 1'b1;
      end
    end

    if (stopCmd) begin
      running_d   = 1'b0;
      prescaler_d = prescaler_q;
      msCount_d   = msCount_q;
      overflow_d  = overflow_q;
    end else if (startCmd) begin
      running_d   = 1'b1;
      prescaler_d = SHORT_COUNT_START;
    end

    if (clearCmd) begin
      msCount_d   = 16'd0;
      prescaler_d = SHORT_COUNT_START;
      overflow_d  = 1'b0;
    end
  end

  // Read path: registered data, low-byte reads latch the matching high byte into the shadow
  always_comb begin
    dataOut_d  = dataOut_q;
    shadowHi_d = shadowHi_q;
    if (read_en) begin
      case (addr)
        2'd0: dataOut_d = {5'b0, overflow_q, capturePending, running_q};
        2'd1: begin
          dataOut_d  = msCount_q[7:0];
          shadowHi_d = msCount_q[15:8];
        end
        2'd2: dataOut_d = shadowHi_q;
        default: begin
`ifdef MILLIS_STOPWATCH_CAPTURE_EN
          dataOut_d  = captureReg_q[7:0];
          shadowHi_d = captureReg_q[15:8];
`else
          dataOut_d  = 8'h00;
`endif
        end
      endcase
    end
  end

  // Main state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_q <= SHORT_COUNT_START;
      msCount_q   <= 16'd0;
      shadowHi_q  <= 8'd0;
      dataOut_q   <= 8'd0;
      running_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      msCount_q   <= msCount_d;
      shadowHi_q  <= shadowHi_d;
      dataOut_q   <= dataOut_d;
      running_q   <= running_d;
      overflow_q  <= overflow_d;
    end
  end

  assign data_out = dataOut_q;
  assign running  = running_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_millis_stopwatch.sv
// Testbench for millis_stopwatch with a 5-cycle millisecond tick.
// Read responses are checked by a scoreboard monitor; status pins are checked directly.
module tb_millis_stopwatch;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [7:0] data_in = 8'd0;
  logic       write_en = 1'b0;
  logic       read_en = 1'b0;
  logic [7:0] data_out;
  logic       running;
  logic       overflow;
  logic       capture_in = 1'b0;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] expQ[$];
  string      nameQ[$];
  logic       respDue = 1'b0;

  always #5 clk = ~clk;

  millis_stopwatch #(.SHORT_COUNT_START(16'd4)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .data_in    (data_in),
    .write_en   (write_en),
    .read_en    (read_en),
    .data_out   (data_out),
    .running    (running),
    .overflow   (overflow),
    .capture_in (capture_in)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic doWrite, input logic doRead, input logic [1:0] a,
                               input logic [7:0] wdata, input logic [7:0] expRead, input string name);
    addr     = a;
    data_in  = wdata;
    write_en = doWrite;
    read_en  = doRead;
    if (doRead) begin
      expQ.push_back(expRead);
      nameQ.push_back(name);
    end
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, a, d, 8'h00, "");
  endtask

  task automatic readReg(input logic [1:0] a, input logic [7:0] expected, input string name);
    applyStimulus(1'b0, 1'b1, a, 8'h00, expected, name);
  endtask

  // Note which cycles carry a read response
  always @(posedge clk) respDue <= read_en && !reset;

  // Monitor: pop the expected byte whenever a read response is presented
  always @(negedge clk) begin
    if (respDue) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_read: got 0x%0h, expected no response", data_out);
      end else begin
        checkOutput(nameQ.pop_front(), {8'h00, data_out}, {8'h00, expQ.pop_front()});
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cycles(3);
    reset = 1'b0;
    checkOutput("reset_running", {15'd0, running}, 16'd0);
    checkOutput("reset_overflow", {15'd0, overflow}, 16'd0);
    checkOutput("reset_data_out", {8'h00, data_out}, 16'd0);
    readReg(2'd0, 8'h00, "reset_status");
    readReg(2'd1, 8'h00, "reset_low");
    readReg(2'd2, 8'h00, "reset_high");
    readReg(2'd3, 8'h00, "reset_capture");

    // Run 300 ms, then read low byte and shadowed high byte
    writeReg(2'd0, 8'h01);
    cycles(1501);
    checkOutput("run_running", {15'd0, running}, 16'd1);
    readReg(2'd1, 8'h2C, "run300_low");
    readReg(2'd2, 8'h01, "run300_high");
    readReg(2'd0, 8'h01, "run_status");

    // STOP on the tick edge suppresses the increment
    writeReg(2'd0, 8'h02);
    cycles(100);
    checkOutput("stop_running", {15'd0, running}, 16'd0);
    readReg(2'd1, 8'h2C, "stop_tick_low");
    readReg(2'd2, 8'h01, "stop_tick_high");

    // START together with STOP leaves it stopped
    writeReg(2'd0, 8'h03);
    checkOutput("startstop_running", {15'd0, running}, 16'd0);

    // START: first tick exactly five cycles after the write edge
    writeReg(2'd0, 8'h01);
    cycles(4);
    readReg(2'd1, 8'h2C, "start_tick_pre");
    readReg(2'd1, 8'h2D, "start_tick_post");

    // STOP mid-prescale freezes the count
    writeReg(2'd0, 8'h02);
    cycles(100);
    readReg(2'd1, 8'h2D, "stop_mid_low");
    readReg(2'd2, 8'h01, "stop_mid_high");

    // Wrap from 0xFFFF to 0x0000 sets sticky overflow
    force dut.msCount_q = 16'hFFFE;
    cycles(1);
    release dut.msCount_q;
    writeReg(2'd0, 8'h01);
    cycles(5);
    checkOutput("pre_wrap_overflow", {15'd0, overflow}, 16'd0);
    cycles(5);
    checkOutput("wrap_overflow", {15'd0, overflow}, 16'd1);
    writeReg(2'd0, 8'h02);
    readReg(2'd0, 8'h04, "wrap_status");
    readReg(2'd1, 8'h00, "wrap_low");
    readReg(2'd2, 8'h00, "wrap_high");
    writeReg(2'd0, 8'h04);
    checkOutput("clear_overflow", {15'd0, overflow}, 16'd0);
    readReg(2'd0, 8'h00, "clear_status");

    // Low-byte read on the tick edge stays coherent with the shadow
    force dut.msCount_q = 16'h00FF;
    cycles(1);
    release dut.msCount_q;
    writeReg(2'd0, 8'h01);
    cycles(4);
    readReg(2'd1, 8'hFF, "coherent_low");
    readReg(2'd2, 8'h00, "coherent_high");
    readReg(2'd1, 8'h00, "after_tick_low");
    readReg(2'd2, 8'h01, "after_tick_high");

    // CLEAR on a tick edge wins over the increment and keeps running
    cycles(1);
    writeReg(2'd0, 8'h04);
    checkOutput("clear_tick_running", {15'd0, running}, 16'd1);
    readReg(2'd1, 8'h00, "clear_tick_low");
    readReg(2'd2, 8'h00, "clear_tick_high");
    writeReg(2'd0, 8'h02);

    force dut.msCount_q = 16'h0123;
    cycles(1);
    release dut.msCount_q;
    capture_in = 1'b1;
    cycles(3);
`ifdef MILLIS_STOPWATCH_CAPTURE_EN
    readReg(2'd0, 8'h02, "capture_pending");
    capture_in = 1'b0;
    readReg(2'd3, 8'h23, "capture_low");
    readReg(2'd2, 8'h01, "capture_high");
    readReg(2'd0, 8'h00, "capture_cleared");
`else
    readReg(2'd0, 8'h00, "nocapture_status");
    capture_in = 1'b0;
    readReg(2'd3, 8'h00, "nocapture_low");
    readReg(2'd2, 8'h00, "nocapture_shadow");
`endif

    // Reset mid-count restores everything
    writeReg(2'd0, 8'h01);
    cycles(7);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    checkOutput("midreset_running", {15'd0, running}, 16'd0);
    checkOutput("midreset_overflow", {15'd0, overflow}, 16'd0);
    checkOutput("midreset_data_out", {8'h00, data_out}, 16'd0);
    readReg(2'd1, 8'h00, "midreset_low");
    readReg(2'd2, 8'h00, "midreset_high");

    cycles(3);
    checkOutput("queue_drained", 16'(expQ.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/millis_stopwatch.md
Name: millis_stopwatch

Overview:
- Free-running elapsed-time counter in milliseconds. It measures time, where the countdown timer waits for time to expire.
- CPU starts, stops and clears it through a byte-wide register port, then reads the 16-bit count tear-free via a shadow latch.
- Sits on the peripheral bus beside the millis countdown timer and shares its 50 MHz / 1 ms prescaler convention.

Parameters:
- SHORT_COUNT_START, 16'd49999: prescaler reload value; one ms tick every SHORT_COUNT_START+1 cycles.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- addr  input  2  register select
- data_in  input  8  write data
- write_en  input  1  register write strobe
- read_en  input  1  register read strobe (side effects only when high)
- data_out  output  8  read data, registered
- running  output  1  counter is enabled
- overflow  output  1  sticky: ms count wrapped
- capture_in  input  1  async event input (used only with optional feature)

Behaviour:
- State: prescaler[15:0], ms_count[15:0], shadow_hi[7:0], running, overflow.
- Reset values:
  - prescaler = SHORT_COUNT_START; ms_count = 0; shadow_hi = 0.
  - running = 0; overflow = 0; data_out = 0.
  - capture_reg = 0; capture_pending = 0; synchronizer flops = 0.
- Register map:
  - addr0 write: control. bit0 START, bit1 STOP, bit2 CLEAR; other bits ignored.
  - addr0 read: status {5'b0, overflow, capture_pending, running}.
  - addr1 read: returns ms_count[7:0]; same cycle latches shadow_hi <= ms_count[15:8].
  - addr2 read: returns shadow_hi.
  - addr3 read: capture low byte (see Optional Feature).
  - Writes to addr1..3 are ignored.
- Reads: data_out updates on the clock edge where read_en=1, so data is valid the cycle after the strobe. data_out holds its value when read_en=0.
- Counting, while running=1:
  - Prescaler decrements each cycle.
  - When prescaler==0: reload SHORT_COUNT_START and ms_count += 1.
  - 0xFFFF -> 0x0000 wrap sets overflow=1 (sticky).
- Stopped (running=0): prescaler and ms_count frozen.
- START: running <= 1 and prescaler reloads, so the first tick is exactly SHORT_COUNT_START+1 cycles after the write edge. START while already running also reloads.
- STOP: running <= 0; the partial prescaler value is retained.
- CLEAR: ms_count <= 0, prescaler reloads, overflow <= 0. running is unchanged unless START/STOP are also set.
- Simultaneous control bits:
  - START and STOP together: STOP wins.
  - CLEAR with START: cleared and running.
- Write with coincident tick: CLEAR wins over the increment. STOP wins over the tick; the increment is suppressed and the prescaler is held at 0.
- Read with coincident tick: the addr1 read returns the pre-increment low byte and shadow_hi gets the pre-increment high byte, so the pair is coherent.
- Simultaneous write_en and read_en are legal; both take effect.
- reset mid-count restores all reset values on the next edge.

Optional Feature:
- Macro: MILLIS_STOPWATCH_CAPTURE_EN.
- With the macro defined:
  - capture_in passes through a 2-flop synchronizer plus rising-edge detect, 3 cycles total latency from pin to capture.
  - On an edge: capture_reg <= ms_count (the value before any coincident tick) and capture_pending <= 1.
  - addr3 read returns capture_reg[7:0], latches shadow_hi <= capture_reg[15:8], and clears capture_pending.
  - Edge coincident with an addr3 read: the new capture is stored and pending stays 1. The read returns the old low byte and shadow_hi gets the old high byte.
  - Captures occur whether or not running=1.
- Without the macro: capture_in is ignored, addr3 reads 0x00 with no shadow update, and status bit1 reads 0. No capture logic is synthesized.

Test Plan:
- Bench uses SHORT_COUNT_START=4 (5-cycle tick).
- Reset, then read addr0 -> data_out 0x00. Read addr1 then addr2 -> 0x00, 0x00.
- Write addr0=0x01 and wait 5*300+1 cycles -> running=1. Read addr1 returns 0x2C, then addr2 returns 0x01 (300 ms).
- Preload to 0xFFFE via run; STOP; START; run 2 ticks -> count 0x0000, overflow=1, status 0x04. Write CLEAR (0x04) -> overflow=0, count 0.
- Count at 0x00FF with a tick due: read addr1 in the tick cycle -> 0xFF. Subsequent addr2 read -> 0x00 (not 0x01), despite ms_count now 0x0100.
- Write 0x03 (START+STOP) -> running stays 0. Write STOP mid-prescale, wait 100 cycles -> count unchanged. Write START -> next tick exactly 5 cycles later.
- [CAPTURE_EN] Count=0x0123, pulse capture_in -> capture_pending=1 within 3 cycles. addr3 read returns 0x23, addr2 read returns 0x01, then status bit1 = 0.
